// File: rtl/regfile_seq_ctrl.sv
// ============================================================================
// Module : regfile_seq_ctrl
// Brief  : Restartable sequencer driving regfile write enables, A/B selects
//          and instruction word: seeds r0/r1, then r[k] = r[k-2] OP r[k-1].
//          Optional macro SEQ_SINGLE_STEP_EN adds a 'step' input gating RUN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_seq_ctrl #(
  parameter int NUM_REGS  = 16,
  parameter int REG_IDX_W = 4,
  parameter int INST_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                 step,
`endif
  input  logic [INST_W-1:0]    seed_inst,
  input  logic [INST_W-1:0]    op_inst,
  output logic [NUM_REGS-1:0]  reg_en,
  output logic [REG_IDX_W-1:0] ctrl_a,
  output logic [REG_IDX_W-1:0] ctrl_b,
  output logic [INST_W-1:0]    inst,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEED = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [REG_IDX_W-1:0] K_FIRST  = REG_IDX_W'(2);
  localparam logic [REG_IDX_W-1:0] K_LAST   = REG_IDX_W'(NUM_REGS - 1);
  localparam logic [REG_IDX_W-1:0] IDX_ZERO = '0;
  localparam logic [REG_IDX_W-1:0] IDX_ONE  = REG_IDX_W'(1);
  localparam logic [NUM_REGS-1:0]  EN_ONE   = NUM_REGS'(1);
  localparam logic [NUM_REGS-1:0]  EN_SEED  = NUM_REGS'(3);

  state_t                state_q, state_d;
  logic [REG_IDX_W-1:0]  k_q, k_d;
  logic [INST_W-1:0]     op_q, op_d;
  logic                  adv;

`ifdef SEQ_SINGLE_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= K_FIRST;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      op_q    <= op_d;
    end
  end

  // Outputs depend only on registered state, except the live seed word in SEED
  // and the step qualifier on the RUN write enable.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    op_d    = op_q;
    reg_en  = '0;
    ctrl_a  = IDX_ZERO;
    ctrl_b  = IDX_ONE;
    inst    = '0;
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SEED;
          op_d    = op_inst;
        end
      end

      S_SEED: begin
        reg_en  = EN_SEED;
        inst    = seed_inst;
        busy    = 1'b1;
        state_d = S_RUN;
        k_d     = K_FIRST;
      end

      S_RUN: begin
        ctrl_a = k_q - K_FIRST;
        ctrl_b = k_q - IDX_ONE;
        inst   = op_q;
        busy   = 1'b1;
        if (adv) begin
          reg_en = EN_ONE << k_q;
          if (k_q == K_LAST) begin
            state_d = S_DONE;
          end else begin
            k_d = k_q + IDX_ONE;
          end
        end
      end

      S_DONE: begin
        ctrl_a = K_LAST - IDX_ONE;
        ctrl_b = K_LAST;
        inst   = op_q;
        done   = 1'b1;
        if (start) begin
          state_d = S_SEED;
          op_d    = op_inst;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_seq_ctrl.sv
// ============================================================================
// Module : tb_regfile_seq_ctrl
// Brief  : Directed self-checking bench for regfile_seq_ctrl (16- and 4-reg).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        step = 1'b1;
  logic [15:0] seed_inst = 16'h00A5;
  logic [15:0] op_inst = 16'h0000;

  logic [15:0] reg_en;
  logic [3:0]  ctrl_a, ctrl_b;
  logic [15:0] inst;
  logic        busy, done;

  logic        start4 = 1'b0;
  logic [3:0]  reg_en4;
  logic [1:0]  a4, b4;
  logic [15:0] inst4;
  logic        busy4, done4;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [15:0] rf [16];

  always #5 clk = ~clk;

  regfile_seq_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
`ifdef SEQ_SINGLE_STEP_EN
    .step     (step),
`endif
    .seed_inst(seed_inst),
    .op_inst  (op_inst),
    .reg_en   (reg_en),
    .ctrl_a   (ctrl_a),
    .ctrl_b   (ctrl_b),
    .inst     (inst),
    .busy     (busy),
    .done     (done)
  );

  regfile_seq_ctrl #(.NUM_REGS(4), .REG_IDX_W(2), .INST_W(16)) dut4 (
    .clk      (clk),
    .reset    (reset),
    .start    (start4),
`ifdef SEQ_SINGLE_STEP_EN
    .step     (step),
`endif
    .seed_inst(seed_inst),
    .op_inst  (op_inst),
    .reg_en   (reg_en4),
    .ctrl_a   (a4),
    .ctrl_b   (b4),
    .inst     (inst4),
    .busy     (busy4),
    .done     (done4)
  );

  // Datapath stand-in: seeding loads r0=0, r1=1; RUN writes r[a] + r[b].
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) rf[i] <= 16'h0000;
    end else if (reg_en == 16'h0003) begin
      rf[0] <= 16'h0000;
      rf[1] <= 16'h0001;
    end else begin
      for (int i = 0; i < 16; i++)
        if (reg_en[i]) rf[i] <= rf[ctrl_a] + rf[ctrl_b];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observed tuple layout: {reg_en[16], a[4], b[4], inst[16], busy, done}
  task automatic test_reset();
    logic [41:0] obs, exp;
    logic [25:0] obs4, exp4;
    #12;
    obs = {reg_en, ctrl_a, ctrl_b, inst, busy, done};
    exp = {16'h0000, 4'd0, 4'd1, 16'h0000, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp) $display("FAIL reset_state got=%h exp=%h", obs, exp);
    else pass_cnt++;
    obs4 = {reg_en4, a4, b4, inst4, busy4, done4};
    exp4 = {4'h0, 2'd0, 2'd1, 16'h0000, 1'b0, 1'b0};
    total_cnt++;
    if (obs4 !== exp4) $display("FAIL reset_state4 got=%h exp=%h", obs4, exp4);
    else pass_cnt++;
    tick();
    reset = 1'b0;
    tick();
    tick();
    obs = {reg_en, ctrl_a, ctrl_b, inst, busy, done};
    total_cnt++;
    if (obs !== exp) $display("FAIL idle_after_reset got=%h exp=%h", obs, exp);
    else pass_cnt++;
  endtask

  task automatic test_full_run();
    logic [41:0] obs, exp;
    int busy_cycles;
    busy_cycles = 0;
    op_inst = 16'h0090;
    start = 1'b1;
    tick();
    start = 1'b0;
    obs = {reg_en, ctrl_a, ctrl_b, inst, busy, done};
    exp = {16'h0003, 4'd0, 4'd1, 16'h00A5, 1'b1, 1'b0};
    total_cnt++;
    if (obs !== exp) $display("FAIL t1_seed got=%h exp=%h", obs, exp);
    else pass_cnt++;
    if (busy) busy_cycles++;
    for (int k = 2; k <= 15; k++) begin
      tick();
      obs = {reg_en, ctrl_a, ctrl_b, inst, busy, done};
      exp = {16'h0001 << k, 4'(k - 2), 4'(k - 1), 16'h0090, 1'b1, 1'b0};
      total_cnt++;
      if (obs !== exp) $display("FAIL t1_run_k%0d got=%h exp=%h", k, obs, exp);
      else pass_cnt++;
      if (busy) busy_cycles++;
    end
    tick();
    obs = {reg_en, ctrl_a, ctrl_b, inst, busy, done};
    exp = {16'h0000, 4'd14, 4'd15, 16'h0090, 1'b0, 1'b1};
    total_cnt++;
    if (obs !== exp) $display("FAIL t1_done got=%h exp=%h", obs, exp);
    else pass_cnt++;
    total_cnt++;
    if (busy_cycles !== 15) $display("FAIL t1_busy_len got=%0d exp=15", busy_cycles);
    else pass_cnt++;
    tick();
    obs = {reg_en, ctrl_a, ctrl_b, inst, busy, done};
    total_cnt++;
    if (obs !== exp) $display("FAIL t1_done_hold got=%h exp=%h", obs, exp);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    logic [41:0] obs, exp;
    op_inst = 16'h0090;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 2; k <= 7; k++) tick();
    total_cnt++;
    if (reg_en !== 16'h0080) $display("FAIL t2_at_k7 got=%h exp=%h", reg_en, 16'h0080);
    else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    obs = {reg_en, ctrl_a, ctrl_b, inst, busy, done};
    exp = {16'h0000, 4'd0, 4'd1, 16'h0000, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp) $display("FAIL t2_async_reset got=%h exp=%h", obs, exp);
    else pass_cnt++;
    #3 reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      obs = {reg_en, ctrl_a, ctrl_b, inst, busy, done};
      total_cnt++;
      if (obs !== exp) $display("FAIL t2_post_reset_c%0d got=%h exp=%h", c, obs, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_start_held();
    logic [41:0] obs, exp;
    op_inst = 16'h0090;
    start = 1'b1;
    tick();
    total_cnt++;
    if (reg_en !== 16'h0003) $display("FAIL t3_seed got=%h exp=%h", reg_en, 16'h0003);
    else pass_cnt++;
    for (int k = 2; k <= 15; k++) begin
      tick();
      obs = {reg_en, ctrl_a, ctrl_b, inst, busy, done};
      exp = {16'h0001 << k, 4'(k - 2), 4'(k - 1), 16'h0090, 1'b1, 1'b0};
      total_cnt++;
      if (obs !== exp) $display("FAIL t3_run_k%0d got=%h exp=%h", k, obs, exp);
      else pass_cnt++;
      if (k == 8) op_inst = 16'h00B0;
    end
    tick();
    obs = {reg_en, ctrl_a, ctrl_b, inst, busy, done};
    exp = {16'h0000, 4'd14, 4'd15, 16'h0090, 1'b0, 1'b1};
    total_cnt++;
    if (obs !== exp) $display("FAIL t3_done got=%h exp=%h", obs, exp);
    else pass_cnt++;
    tick();
    obs = {reg_en, ctrl_a, ctrl_b, inst, busy, done};
    exp = {16'h0003, 4'd0, 4'd1, 16'h00A5, 1'b1, 1'b0};
    total_cnt++;
    if (obs !== exp) $display("FAIL t3_reseed got=%h exp=%h", obs, exp);
    else pass_cnt++;
    tick();
    start = 1'b0;
    obs = {reg_en, ctrl_a, ctrl_b, inst, busy, done};
    exp = {16'h0004, 4'd0, 4'd1, 16'h00B0, 1'b1, 1'b0};
    total_cnt++;
    if (obs !== exp) $display("FAIL t3_new_op got=%h exp=%h", obs, exp);
    else pass_cnt++;
    for (int k = 3; k <= 15; k++) tick();
    tick();
    obs = {reg_en, ctrl_a, ctrl_b, inst, busy, done};
    exp = {16'h0000, 4'd14, 4'd15, 16'h00B0, 1'b0, 1'b1};
    total_cnt++;
    if (obs !== exp) $display("FAIL t3_done2 got=%h exp=%h", obs, exp);
    else pass_cnt++;
  endtask

  task automatic test_small_depth();
    logic [25:0] obs, exp;
    logic [25:0] exp_tab [4];
    int busy_cycles;
    busy_cycles = 0;
    op_inst = 16'h0090;
    exp_tab[0] = {4'b0011, 2'd0, 2'd1, 16'h00A5, 1'b1, 1'b0};
    exp_tab[1] = {4'b0100, 2'd0, 2'd1, 16'h0090, 1'b1, 1'b0};
    exp_tab[2] = {4'b1000, 2'd1, 2'd2, 16'h0090, 1'b1, 1'b0};
    exp_tab[3] = {4'b0000, 2'd2, 2'd3, 16'h0090, 1'b0, 1'b1};
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      obs = {reg_en4, a4, b4, inst4, busy4, done4};
      exp = exp_tab[i];
      total_cnt++;
      if (obs !== exp) $display("FAIL t4_step%0d got=%h exp=%h", i, obs, exp);
      else pass_cnt++;
      if (busy4) busy_cycles++;
      tick();
    end
    total_cnt++;
    if (busy_cycles !== 3) $display("FAIL t4_busy_len got=%0d exp=3", busy_cycles);
    else pass_cnt++;
  endtask

  task automatic test_datapath();
    int guard;
    op_inst = 16'h0090;
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (!done && guard < 40) begin
      tick();
      guard++;
    end
    total_cnt++;
    if (done !== 1'b1) $display("FAIL t6_timeout got=%b exp=1", done);
    else pass_cnt++;
    total_cnt++;
    if (rf[ctrl_b] !== 16'h0262) $display("FAIL t6_bus got=%h exp=%h", rf[ctrl_b], 16'h0262);
    else pass_cnt++;
  endtask

`ifdef SEQ_SINGLE_STEP_EN
  task automatic test_single_step();
    int k, c, steps;
    k = 2;
    c = 0;
    steps = 0;
    op_inst = 16'h0090;
    step = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    while (!done && c < 100) begin
      step = (c % 3 == 2);
      #1;
      total_cnt++;
      if (reg_en !== (step ? (16'h0001 << k) : 16'h0000) || ctrl_a !== 4'(k - 2) || ctrl_b !== 4'(k - 1))
        $display("FAIL t5_c%0d got=%h/%0d/%0d k=%0d step=%b", c, reg_en, ctrl_a, ctrl_b, k, step);
      else pass_cnt++;
      if (step) begin
        k++;
        steps++;
      end
      tick();
      c++;
    end
    step = 1'b1;
    total_cnt++;
    if (done !== 1'b1 || steps !== 14) $display("FAIL t5_done got=%b steps=%0d exp=1 steps=14", done, steps);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_full_run();
    test_reset_mid_run();
    test_start_held();
    test_small_depth();
    test_datapath();
`ifdef SEQ_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
